// File: rtl/trig_led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trig_led_seq_pkg
// Purpose  : Shared types and constants for the triggered LED / camera
//            sequencer: FSM state encoding, overrun counter width, default
//            parameter values and the saturating overrun update helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package trig_led_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int OVR_W        = 16;
  localparam int DEF_NUM_LED  = 12;
  localparam int DEF_NUM_TRIG = 6;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_SHOT_W   = 4;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  function automatic logic [OVR_W-1:0] ovr_next(input logic [OVR_W-1:0] cur,
                                                input logic             inc,
                                                input logic             clr);
    logic [OVR_W-1:0] res;
    res = cur;
    if (clr) begin
      res = '0;
    end else if (inc && (cur != {OVR_W{1'b1}})) begin
      res = cur + OVR_W'(1);
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trig_led_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : trig_led_seq_if
// Purpose  : Bundles the trigger input, sequence configuration, window
//            tables, polarity controls and status outputs of trig_led_seq.
// Ports    : slave modport  - sequencer side (config in, status/PWM out)
//            master modport - controller side (config out, status/PWM in)
// Revision : 1.0 - initial release
// ============================================================================
interface trig_led_seq_if #(
  parameter int NUM_LED  = trig_led_seq_pkg::DEF_NUM_LED,
  parameter int NUM_TRIG = trig_led_seq_pkg::DEF_NUM_TRIG,
  parameter int CNT_W    = trig_led_seq_pkg::DEF_CNT_W,
  parameter int SHOT_W   = trig_led_seq_pkg::DEF_SHOT_W
);

  logic                         trigger_i;
  logic                         retrig_mode_i;
  logic [CNT_W-1:0]             cnt_max_i;
  logic [SHOT_W-1:0]            shot_num_i;
  logic [NUM_LED*CNT_W-1:0]     led_start_i;
  logic [NUM_LED*CNT_W-1:0]     led_end_i;
  logic [NUM_TRIG*CNT_W-1:0]    trig_start_i;
  logic [NUM_TRIG*CNT_W-1:0]    trig_end_i;
  logic [NUM_TRIG-1:0]          trig_en_i;
  logic [NUM_LED-1:0]           led_polar_i;
  logic                         trig_polar_i;
  logic                         overrun_clr_i;

  logic [NUM_LED-1:0]           led_pwm_o;
  logic                         trigger_o;
  logic                         busy_o;
  logic [SHOT_W-1:0]            shot_idx_o;
  logic                         done_o;
  logic [trig_led_seq_pkg::OVR_W-1:0] overrun_cnt_o;

  modport slave (
    input  trigger_i, retrig_mode_i, cnt_max_i, shot_num_i,
    input  led_start_i, led_end_i, trig_start_i, trig_end_i, trig_en_i,
    input  led_polar_i, trig_polar_i, overrun_clr_i,
    output led_pwm_o, trigger_o, busy_o, shot_idx_o, done_o, overrun_cnt_o
  );

  modport master (
    output trigger_i, retrig_mode_i, cnt_max_i, shot_num_i,
    output led_start_i, led_end_i, trig_start_i, trig_end_i, trig_en_i,
    output led_polar_i, trig_polar_i, overrun_clr_i,
    input  led_pwm_o, trigger_o, busy_o, shot_idx_o, done_o, overrun_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/trig_led_win.sv
`default_nettype none
// ============================================================================
// Module   : trig_led_win
// Purpose  : One LED PWM channel: registered half-open window compare
//            (win_start <= cnt < win_end, unsigned) followed by a
//            combinational polarity XOR.
// Ports    : clk, rst_n          - clock, async active-low reset
//            cnt                 - sequence counter
//            win_start, win_end  - window bounds (start >= end: never on)
//            polar               - output inversion
//            pwm                 - channel output
// Revision : 1.0 - initial release
// ============================================================================
module trig_led_win #(
  parameter int CNT_W = trig_led_seq_pkg::DEF_CNT_W
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [CNT_W-1:0] cnt,
  input  wire logic [CNT_W-1:0] win_start,
  input  wire logic [CNT_W-1:0] win_end,
  input  wire logic             polar,
  output logic                  pwm
);

  logic hit;
  logic win_reg;

  assign hit = (cnt >= win_start) && (cnt < win_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_reg <= 1'b0;
    end else begin
      win_reg <= hit;
    end
  end

  // Polarity is applied after the register so reset shows the idle level.
  assign pwm = win_reg ^ polar;

endmodule
`default_nettype wire

// File: rtl/trig_led_seq.sv
`default_nettype none
// ============================================================================
// Module   : trig_led_seq
// Purpose  : Trigger-started shot sequencer. A rising edge on trigger_i
//            starts shot_num shots of cnt_max cycles each; LED channels and
//            the camera trigger are driven from windows on the counter.
//            Optional macro TRIG_LED_SEQ_SHADOW_EN latches all timing
//            configuration at each accepted start.
// Ports    : clk_i   - clock
//            rst_n_i - asynchronous active-low reset
//            bus     - trig_led_seq_if.slave (trigger, config, windows,
//                      polarity, PWM/trigger outputs, status)
// Revision : 1.0 - initial release
// ============================================================================
module trig_led_seq
  import trig_led_seq_pkg::*;
#(
  parameter int NUM_LED  = DEF_NUM_LED,
  parameter int NUM_TRIG = DEF_NUM_TRIG,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SHOT_W   = DEF_SHOT_W
) (
  input  wire logic     clk_i,
  input  wire logic     rst_n_i,
  trig_led_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [SHOT_W-1:0]         shot_idx, shot_nxt;
  logic                      done_q, done_nxt;
  logic                      trig_d;
  logic                      trig_edge;
  logic [OVR_W-1:0]          overrun_cnt;
  logic                      trig_hit;
  logic                      trig_reg;
  logic [NUM_LED-1:0]        led_pwm;
  logic [SHOT_W:0]           eff_shots;
  logic                      shot_last;

  // Effective configuration: shadow copies or live inputs.
  logic [CNT_W-1:0]          cfg_cnt_max;
  logic [SHOT_W-1:0]         cfg_shot_num;
  logic [NUM_LED*CNT_W-1:0]  cfg_led_start;
  logic [NUM_LED*CNT_W-1:0]  cfg_led_end;
  logic [NUM_TRIG*CNT_W-1:0] cfg_trig_start;
  logic [NUM_TRIG*CNT_W-1:0] cfg_trig_end;
  logic [NUM_TRIG-1:0]       cfg_trig_en;

  // ---------------------------------------------------------------- edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_d <= 1'b0;
    end else begin
      trig_d <= bus.trigger_i;
    end
  end

  assign trig_edge = bus.trigger_i & ~trig_d;

`ifdef TRIG_LED_SEQ_SHADOW_EN
  // ------------------------------------------------------------- shadow
  logic                      start_acc;
  logic [CNT_W-1:0]          sh_cnt_max;
  logic [SHOT_W-1:0]         sh_shot_num;
  logic [NUM_LED*CNT_W-1:0]  sh_led_start;
  logic [NUM_LED*CNT_W-1:0]  sh_led_end;
  logic [NUM_TRIG*CNT_W-1:0] sh_trig_start;
  logic [NUM_TRIG*CNT_W-1:0] sh_trig_end;
  logic [NUM_TRIG-1:0]       sh_trig_en;

  // A start is accepted from IDLE always, and from RUN only in restart mode.
  assign start_acc = trig_edge && ((state == IDLE) || bus.retrig_mode_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_cnt_max    <= '0;
      sh_shot_num   <= '0;
      sh_led_start  <= '0;
      sh_led_end    <= '0;
      sh_trig_start <= '0;
      sh_trig_end   <= '0;
      sh_trig_en    <= '0;
    end else if (start_acc) begin
      sh_cnt_max    <= bus.cnt_max_i;
      sh_shot_num   <= bus.shot_num_i;
      sh_led_start  <= bus.led_start_i;
      sh_led_end    <= bus.led_end_i;
      sh_trig_start <= bus.trig_start_i;
      sh_trig_end   <= bus.trig_end_i;
      sh_trig_en    <= bus.trig_en_i;
    end
  end

  assign cfg_cnt_max    = sh_cnt_max;
  assign cfg_shot_num   = sh_shot_num;
  assign cfg_led_start  = sh_led_start;
  assign cfg_led_end    = sh_led_end;
  assign cfg_trig_start = sh_trig_start;
  assign cfg_trig_end   = sh_trig_end;
  assign cfg_trig_en    = sh_trig_en;
`else
  assign cfg_cnt_max    = bus.cnt_max_i;
  assign cfg_shot_num   = bus.shot_num_i;
  assign cfg_led_start  = bus.led_start_i;
  assign cfg_led_end    = bus.led_end_i;
  assign cfg_trig_start = bus.trig_start_i;
  assign cfg_trig_end   = bus.trig_end_i;
  assign cfg_trig_en    = bus.trig_en_i;
`endif

  // Shot count of zero still runs one shot; one extra bit avoids overflow
  // of shot_idx+1 at the top of the SHOT_W range.
  assign eff_shots = (cfg_shot_num == '0) ? (SHOT_W+1)'(1) : {1'b0, cfg_shot_num};
  assign shot_last = (({1'b0, shot_idx} + (SHOT_W+1)'(1)) >= eff_shots);

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      cnt      <= '0;
      shot_idx <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      shot_idx <= shot_nxt;
      done_q   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shot_nxt  = shot_idx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (trig_edge) begin
          state_nxt = RUN;
          cnt_nxt   = CNT_ONE;
          shot_nxt  = '0;
        end
      end
      RUN: begin
        // A restart beats every other branch, including the terminal cycle.
        if (trig_edge && bus.retrig_mode_i) begin
          cnt_nxt  = CNT_ONE;
          shot_nxt = '0;
        end else if (cnt < cfg_cnt_max) begin
          cnt_nxt = cnt + CNT_ONE;
        end else if (!shot_last) begin
          cnt_nxt  = CNT_ONE;
          shot_nxt = shot_idx + SHOT_W'(1);
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        shot_nxt  = '0;
      end
    endcase
  end

  // ------------------------------------------------------------- overrun
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overrun_cnt <= '0;
    end else begin
      overrun_cnt <= ovr_next(overrun_cnt, (state == RUN) && trig_edge,
                              bus.overrun_clr_i);
    end
  end

  // -------------------------------------------------------- LED windows
  for (genvar k = 0; k < NUM_LED; k++) begin : g_led
    trig_led_win #(
      .CNT_W (CNT_W)
    ) u_win (
      .clk       (clk_i),
      .rst_n     (rst_n_i),
      .cnt       (cnt),
      .win_start (cfg_led_start[k*CNT_W +: CNT_W]),
      .win_end   (cfg_led_end[k*CNT_W +: CNT_W]),
      .polar     (bus.led_polar_i[k]),
      .pwm       (led_pwm[k])
    );
  end

  // ---------------------------------------------------- trigger windows
  // Inclusive on both ends, unlike the LED windows.
  always_comb begin
    trig_hit = 1'b0;
    for (int j = 0; j < NUM_TRIG; j++) begin
      if (cfg_trig_en[j] &&
          (cnt >= cfg_trig_start[j*CNT_W +: CNT_W]) &&
          (cnt <= cfg_trig_end[j*CNT_W +: CNT_W])) begin
        trig_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_reg <= 1'b0;
    end else begin
      trig_reg <= trig_hit;
    end
  end

  // ------------------------------------------------------------ outputs
  assign bus.led_pwm_o     = led_pwm;
  assign bus.trigger_o     = trig_reg ^ bus.trig_polar_i;
  assign bus.busy_o        = (state == RUN);
  assign bus.shot_idx_o    = shot_idx;
  assign bus.done_o        = done_q;
  assign bus.overrun_cnt_o = overrun_cnt;

endmodule
`default_nettype wire
